// File: rtl/gcd_engine_param.sv
// rtl/gcd_engine_param.sv - iterative GCD engine, subtractive Euclid or binary Stein per request
module gcd_engine_param #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] GCD_OUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             ERR,
  output logic [WIDTH:0]   ITERS
);

  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, x_d, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q;
  logic [WIDTH-1:0] gcd_q;
  logic             done_q, busy_q, err_q;
  logic [WIDTH:0]   iters_q, iters_d;
  logic             term_d;
  logic [WIDTH-1:0] result_d;

  // One algorithm step on the working registers; the operand ordering checks keep subtractions non-negative.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    k_d    = k_q;
    term_d = (x_q == y_q);
    if (!term_d) begin
      if (!mode_q) begin
        if (x_q < y_q) y_d = y_q - x_q;
        else           x_d = x_q - y_q;
      end else begin
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
    end
  end

  always_comb begin
    result_d = mode_q ? (x_q << k_q) : x_q;
    iters_d  = (&iters_q) ? iters_q : iters_q + (WIDTH+1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      gcd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      iters_q <= '0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          if (START) begin
            x_q     <= X;
            y_q     <= Y;
            mode_q  <= MODE;
            k_q     <= '0;
            iters_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            // Degenerate operands finish on the accept edge without entering CALC.
            if (X == '0 && Y == '0) begin
              gcd_q   <= '0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIN;
            end else if (X == '0 || Y == '0) begin
              gcd_q   <= X | Y;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIN;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          iters_q <= iters_d;
          if (term_d) begin
            gcd_q   <= result_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            k_q <= k_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GCD_OUT = gcd_q;
  assign DONE    = done_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;
  assign ITERS   = iters_q;

endmodule

// File: tb/tb_gcd_engine_param.sv
// tb/tb_gcd_engine_param.sv - scoreboard bench for gcd_engine_param at WIDTH=8
module tb_gcd_engine_param;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RESET, START, MODE;
  logic [WIDTH-1:0] X, Y;
  logic [WIDTH-1:0] GCD_OUT;
  logic             DONE, BUSY, ERR;
  logic [WIDTH:0]   ITERS;

  typedef struct {
    int g;
    int e;
    int it;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  gcd_engine_param #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .X(X), .Y(Y),
    .GCD_OUT(GCD_OUT), .DONE(DONE), .BUSY(BUSY), .ERR(ERR), .ITERS(ITERS)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: gcd by remainder Euclid, iteration count by replaying the step rules.
  function automatic exp_t model(input bit mode, input int x, input int y);
    exp_t r;
    int a, b, k, t;
    a = x; b = y;
    while (b != 0) begin t = a % b; a = b; b = t; end
    r.g = a; r.e = (x == 0 && y == 0); r.it = 0; r.lat = 0;
    if (x == 0 || y == 0) return r;
    a = x; b = y; k = 0;
    forever begin
      r.it++;
      if (a == b) break;
      if (!mode) begin
        if (a < b) b = b - a; else a = a - b;
      end else if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2; b = b / 2; k++;
      end else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    r.lat = r.it;
    return r;
  endfunction

  // Caller sits at a negedge; returns at the first negedge after the accept edge.
  task automatic start_op(input bit mode, input int x, input int y);
    MODE = mode; X = x[WIDTH-1:0]; Y = y[WIDTH-1:0]; START = 1'b1;
    exp_q.push_back(model(mode, x, y));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat0);
    exp_t e;
    int lat = lat0;
    int budget = 0;
    while (!DONE && budget < 400) begin
      if (BUSY) lat++;
      @(negedge CLK);
      budget++;
    end
    check_eq({tag, "_done"}, int'(DONE), 1);
    e = exp_q.pop_front();
    check_eq({tag, "_gcd"}, int'(GCD_OUT), e.g);
    check_eq({tag, "_err"}, int'(ERR), e.e);
    check_eq({tag, "_iters"}, int'(ITERS), e.it);
    check_eq({tag, "_busy_cycles"}, lat, e.lat);
    check_eq({tag, "_busy_low"}, int'(BUSY), 0);
  endtask

  task automatic run_op(input string tag, input bit mode, input int x, input int y);
    start_op(mode, x, y);
    wait_done(tag, 0);
  endtask

  initial begin
    int g_hold, it_hold;
    RESET = 1'b1; START = 1'b0; MODE = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check_eq("rst_gcd", int'(GCD_OUT), 0);
    check_eq("rst_done", int'(DONE), 0);
    check_eq("rst_busy", int'(BUSY), 0);
    check_eq("rst_err", int'(ERR), 0);
    check_eq("rst_iters", int'(ITERS), 0);
    @(negedge CLK);

    run_op("sub_12_8", 1'b0, 12, 8);
    check_eq("sub_12_8_abs_iters", int'(ITERS), 3);
    check_eq("sub_12_8_abs_gcd", int'(GCD_OUT), 4);
    g_hold = int'(GCD_OUT); it_hold = int'(ITERS);
    repeat (3) @(negedge CLK);
    check_eq("fin_hold_gcd", int'(GCD_OUT), g_hold);
    check_eq("fin_hold_iters", int'(ITERS), it_hold);
    check_eq("fin_hold_done", int'(DONE), 1);

    run_op("bin_12_8", 1'b1, 12, 8);
    check_eq("bin_12_8_abs_iters", int'(ITERS), 6);
    run_op("sub_255_1", 1'b0, 255, 1);
    check_eq("sub_255_1_abs_iters", int'(ITERS), 255);
    run_op("zero_zero", 1'b0, 0, 0);
    check_eq("zero_zero_abs_err", int'(ERR), 1);
    run_op("zero_9", 1'b1, 0, 9);
    run_op("9_zero", 1'b0, 9, 0);
    run_op("bin_255_255", 1'b1, 255, 255);
    run_op("bin_128_64", 1'b1, 128, 64);

    // START while busy must be ignored.
    start_op(1'b0, 12, 8);
    MODE = 1'b1; X = 8'd5; Y = 8'd5; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("ignore", 1);

    // Reset mid-computation aborts silently; START right after reset is taken.
    start_op(1'b0, 200, 3);
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    void'(exp_q.pop_front());
    check_eq("abort_busy", int'(BUSY), 0);
    check_eq("abort_done", int'(DONE), 0);
    check_eq("abort_gcd", int'(GCD_OUT), 0);
    check_eq("abort_iters", int'(ITERS), 0);
    check_eq("abort_err", int'(ERR), 0);
    run_op("after_rst_7_7", 1'b0, 7, 7);

    // Reset wins over START on the same edge.
    RESET = 1'b1; START = 1'b1; MODE = 1'b0; X = 8'd6; Y = 8'd4;
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    check_eq("rst_prio_busy", int'(BUSY), 0);
    check_eq("rst_prio_done", int'(DONE), 0);

    for (int i = 0; i < 150; i++) begin
      int a, b;
      a = (i % 25 == 0) ? 0 : int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_op("sweep_sub", 1'b0, a, b);
      run_op("sweep_bin", 1'b1, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_engine_param.md
GCD_ENGINE_PARAM -- requirements
Module: gcd_engine_param

Interface
- REQ-001: Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
- REQ-002: Port CLK, input, 1, the single clock; all state changes on its rising edge.
- REQ-003: Port RESET, input, 1, synchronous active-high reset, sampled on the rising edge of CLK.
- REQ-004: Port START, input, 1, request; accepted on an edge where START=1 and BUSY=0.
- REQ-005: Port MODE, input, 1, algorithm select sampled at accept: 0 = subtractive Euclid, 1 = binary (Stein).
- REQ-006: Port X, input, WIDTH, first operand, unsigned, sampled at accept.
- REQ-007: Port Y, input, WIDTH, second operand, unsigned, sampled at accept.
- REQ-008: Port GCD_OUT, output, WIDTH, registered result, valid while DONE=1.
- REQ-009: Port DONE, output, 1, registered level; high from completion until the next accepted START or reset.
- REQ-010: Port BUSY, output, 1, registered; high while a computation is in progress.
- REQ-011: Port ERR, output, 1, registered; high with DONE when both operands were zero.
- REQ-012: Port ITERS, output, WIDTH+1, registered count of CALC cycles used by the last computation; saturates at all-ones.

Function
- REQ-013: FSM states SHALL be IDLE, CALC and FIN; IDLE -> CALC or FIN on accept; CALC -> FIN on termination; FIN -> CALC or FIN on accept.
- REQ-014: START SHALL be accepted in IDLE or FIN only; START while BUSY=1 SHALL be ignored, with no effect on operands, MODE or outputs.
- REQ-015: At accept, the block SHALL clear DONE, ERR and ITERS, latch X, Y and MODE into working registers, clear shift count k, and set BUSY=1, except as in REQ-016/017.
- REQ-016: If X=0 and Y=0 at accept, the block SHALL go directly to FIN with GCD_OUT=0, ERR=1, DONE=1, BUSY=0, ITERS=0.
- REQ-017: If exactly one of X, Y is zero at accept, the block SHALL go directly to FIN with GCD_OUT = the nonzero operand, ERR=0, DONE=1, BUSY=0, ITERS=0.
- REQ-018: Each CALC cycle SHALL increment ITERS (saturating) and perform exactly one step on working registers x, y.
- REQ-019: Subtractive step: if x=y terminate; else if x<y then y<=y-x; else x<=x-y.
- REQ-020: Binary step, priority order: if x=y terminate; else if x and y both even, then x<=x>>1, y<=y>>1, k<=k+1; else if x even, x<=x>>1; else if y even, y<=y>>1; else if x>y, x<=x-y; else y<=y-x.
- REQ-021: Termination SHALL, on the same edge, load GCD_OUT with x (subtractive) or x<<k truncated to WIDTH (binary; never overflows for nonzero inputs), set DONE=1, clear BUSY, and enter FIN.
- REQ-022: All subtractions SHALL be WIDTH-bit unsigned and never underflow; k SHALL be wide enough to hold WIDTH-1.
- REQ-023: Latency from the accept edge to DONE=1 SHALL be exactly ITERS edges for nonzero operands and 1 edge for the zero cases.
- REQ-024: GCD_OUT, ERR and ITERS SHALL hold their values in FIN until the next accept.

Reset
- REQ-025: RESET=1 on an edge SHALL force state IDLE with GCD_OUT=0, DONE=0, BUSY=0, ERR=0, ITERS=0 and k=0, regardless of state or START.
- REQ-026: RESET asserted mid-computation SHALL abort it with no DONE pulse; a START seen on the first edge after RESET deasserts SHALL be accepted normally.
- REQ-027: RESET SHALL take priority over START on the same edge.

Verification (WIDTH=8)
- REQ-028: MODE=0, X=12, Y=8, START for one cycle -> BUSY for 3 cycles, then DONE=1, GCD_OUT=4, ITERS=3, ERR=0.
- REQ-029: MODE=1, X=12, Y=8 -> DONE after 6 CALC cycles, GCD_OUT=4, ITERS=6; MODE=0, X=255, Y=1 -> GCD_OUT=1, ITERS=255.
- REQ-030: X=0, Y=0 -> DONE=1, ERR=1, GCD_OUT=0, ITERS=0 one edge after accept; X=0, Y=9 -> GCD_OUT=9, ERR=0, ITERS=0.
- REQ-031: MODE=0, X=12, Y=8; during CALC, drive START with X=5, Y=5 -> START ignored, result 4.
- REQ-032: MODE=0, X=200, Y=3; assert RESET for one cycle after 10 CALC cycles -> all outputs 0, state IDLE; then MODE=0, X=7, Y=7 -> GCD_OUT=7, ITERS=1.
- REQ-033: Random sweep of all 8-bit operand pairs in both modes against a reference gcd model: GCD_OUT matches, and ITERS matches the step-count model.
